// File: rtl/uart_sample_rx_if.sv
// uart_sample_rx_if
//   Sample-buffer write side of the UART sample receiver.
//   master : driven by uart_sample_rx
//   slave  : seen by the sample FIFO / frame logic
//   Signals:
//     sample_data  [31:0] packed {I,Q}, first byte in [31:24]
//     sample_valid        one-cycle write strobe for sample_data
//     frame_done          one-cycle pulse with the last sample of a frame
//     frame_err           one-cycle pulse on a bad stop bit
//     timeout_err         one-cycle pulse when a partial word is dropped
interface uart_sample_rx_if;
  logic [31:0] sample_data;
  logic        sample_valid;
  logic        frame_done;
  logic        frame_err;
  logic        timeout_err;

  modport master (
    output sample_data,
    output sample_valid,
    output frame_done,
    output frame_err,
    output timeout_err
  );

  modport slave (
    input sample_data,
    input sample_valid,
    input frame_done,
    input frame_err,
    input timeout_err
  );
endinterface

// File: rtl/uart_sample_rx.sv
// uart_sample_rx
//   UART 8N1 receiver that packs four bytes into one 32-bit {I,Q} sample,
//   counts samples into frames and flags stop-bit and inter-byte timeout
//   errors.
//   Ports:
//     clk      system clock
//     rst      asynchronous active-high reset
//     uart_rx  serial line, idle high, asynchronous to clk
//     smp_o    sample-buffer write side (uart_sample_rx_if.master)
module uart_sample_rx #(
  parameter int CLK_FRE      = 100,
  parameter int BAUD_RATE    = 115200,
  parameter int FRAME_LEN    = 128,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             uart_rx,
  uart_sample_rx_if.master smp_o
);

  localparam int CYC_PER_BIT = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int GAP_LIMIT   = TIMEOUT_BITS * CYC_PER_BIT;
  localparam int TMR_W       = $clog2(CYC_PER_BIT + 1);
  localparam int GAP_W       = $clog2(GAP_LIMIT + 1);
  localparam int FCNT_W      = $clog2(FRAME_LEN + 1);

  localparam logic [TMR_W-1:0]  HALF_END = TMR_W'(CYC_PER_BIT / 2 - 1);
  localparam logic [TMR_W-1:0]  BIT_END  = TMR_W'(CYC_PER_BIT - 1);
  localparam logic [GAP_W-1:0]  GAP_END  = GAP_W'(GAP_LIMIT - 1);
  localparam logic [FCNT_W-1:0] FRM_END  = FCNT_W'(FRAME_LEN - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  logic              rx_meta_q, rx_s_q, rx_prev_q;
  logic [2:0]        state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       acc_q, acc_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [31:0]       data_q, data_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;
  logic              tout_q, tout_d;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Receive FSM, byte packing, frame counting and inter-byte timeout.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_idx_d  = byte_idx_q;
    acc_d       = acc_q;
    gap_d       = gap_q;
    frame_cnt_d = frame_cnt_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    done_d      = 1'b0;
    ferr_d      = 1'b0;
    tout_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A start edge wins over a timeout in the same cycle, keeping the word.
        if (!rx_s_q && rx_prev_q) begin
          state_d = S_START;
          tmr_d   = '0;
          gap_d   = '0;
        end else if (byte_idx_q != 2'd0) begin
          if (gap_q == GAP_END) begin
            tout_d     = 1'b1;
            byte_idx_d = 2'd0;
            gap_d      = '0;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end else begin
          gap_d = gap_q;
        end
      end

      S_START: begin
        if (tmr_q == HALF_END) begin
          tmr_d     = '0;
          bit_cnt_d = 3'd0;
          // High at mid-start-bit means the falling edge was a glitch.
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_DATA: begin
        if (tmr_q == BIT_END) begin
          tmr_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_STOP: begin
        if (tmr_q == BIT_END) begin
          tmr_d = '0;
          if (rx_s_q) begin
            state_d    = S_IDLE;
            byte_idx_d = byte_idx_q + 2'd1;
            case (byte_idx_q)
              2'd0:    acc_d[23:16] = shift_q;
              2'd1:    acc_d[15:8]  = shift_q;
              2'd2:    acc_d[7:0]   = shift_q;
              default: begin
                data_d  = {acc_q, shift_q};
                valid_d = 1'b1;
                if (frame_cnt_q == FRM_END) begin
                  done_d      = 1'b1;
                  frame_cnt_d = '0;
                end else begin
                  frame_cnt_d = frame_cnt_q + FCNT_W'(1);
                end
              end
            endcase
          end else begin
            // Bad stop bit: the whole partial word is abandoned.
            ferr_d     = 1'b1;
            byte_idx_d = 2'd0;
            state_d    = S_WAIT_HIGH;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_WAIT_HIGH: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_HIGH;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      byte_idx_q  <= 2'd0;
      acc_q       <= 24'd0;
      gap_q       <= '0;
      frame_cnt_q <= '0;
      data_q      <= 32'd0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      ferr_q      <= 1'b0;
      tout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      byte_idx_q  <= byte_idx_d;
      acc_q       <= acc_d;
      gap_q       <= gap_d;
      frame_cnt_q <= frame_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      ferr_q      <= ferr_d;
      tout_q      <= tout_d;
    end
  end

  assign smp_o.sample_data  = data_q;
  assign smp_o.sample_valid = valid_q;
  assign smp_o.frame_done   = done_q;
  assign smp_o.frame_err    = ferr_q;
  assign smp_o.timeout_err  = tout_q;

endmodule
